// File: rtl/i2c_apb_master_if.sv
// Command/response and APB signal bundle for i2c_apb_master.
// Handshake rule: a transfer happens on a rising edge where valid and ready are both high;
// a valid source holds its payload unchanged until that edge.
interface i2c_apb_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        apb_sel;
  logic        apb_en;
  logic        apb_write;
  logic [31:0] apb_addr;
  logic [31:0] apb_wdata;
  logic        apb_ready;
  logic [31:0] apb_rdata;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready, apb_ready, apb_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output apb_sel, apb_en, apb_write, apb_addr, apb_wdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready, apb_ready, apb_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  apb_sel, apb_en, apb_write, apb_addr, apb_wdata
  );
endinterface

// File: rtl/i2c_apb_master.sv
// Single-outstanding command-to-APB master: IDLE -> SETUP -> ACCESS -> RESP.
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait states.
module i2c_apb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rstn,
  i2c_apb_master_if.master bus,
  output logic [1:0]       dbg_state_o
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

  state_e      state_q, state_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam logic [15:0] WaitLast = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wait_q, wait_d;
  logic        err_q, err_d;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_q  <= wait_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef APB_MASTER_TIMEOUT_EN
    wait_d  = wait_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          wr_d    = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
`ifdef APB_MASTER_TIMEOUT_EN
          wait_d  = '0;
`endif
          state_d = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        // Read data is only trusted on the completing edge of a read.
        if (bus.apb_ready) begin
          rdata_d = wr_q ? 32'd0 : bus.apb_rdata;
`ifdef APB_MASTER_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = RESP;
        end
`ifdef APB_MASTER_TIMEOUT_EN
        else if (wait_q == WaitLast) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else if (wait_q != 16'hFFFF) begin
          wait_d = wait_q + 16'd1;
        end
`endif
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  logic on_bus;
  assign on_bus = (state_q == SETUP) || (state_q == ACCESS);

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = (state_q == RESP) ? rdata_q : 32'd0;
`ifdef APB_MASTER_TIMEOUT_EN
  assign bus.rsp_err   = (state_q == RESP) && err_q;
`else
  assign bus.rsp_err   = 1'b0;
`endif

  assign bus.apb_sel   = on_bus;
  assign bus.apb_en    = (state_q == ACCESS);
  assign bus.apb_write = on_bus && wr_q;
  assign bus.apb_addr  = on_bus ? addr_q : 32'd0;
  assign bus.apb_wdata = on_bus ? wdata_q : 32'd0;

  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_i2c_apb_master.sv
// Self-checking bench for i2c_apb_master: directed cases plus randomized commands
// against a register-array reference model and a simple wait-state APB slave.
module tb_i2c_apb_master;
  localparam int TB_TIMEOUT = 4;

  logic       clk;
  logic       rstn;
  logic [1:0] dbg_state;

  i2c_apb_master_if bus();

  i2c_apb_master #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int          n_vec = 0;
  int          n_miss = 0;
  int          cyc = 0;
  logic [31:0] exp_q[$];
  logic [31:0] slv_mem [64];
  logic [31:0] model_mem [64];
  int          slv_waits = 0;
  int          slv_cnt = 0;
  logic        nxt_wr = 1'b0;
  logic [31:0] nxt_addr = '0;
  logic [31:0] nxt_wdata = '0;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1);
  end

  // APB slave: ready after slv_waits ACCESS cycles, noise on rdata/ready otherwise
  initial begin
    bus.apb_ready = 1'b0;
    bus.apb_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.apb_sel && bus.apb_en) begin
        if (slv_cnt >= slv_waits) begin
          bus.apb_ready = 1'b1;
          if (bus.apb_write) begin
            slv_mem[bus.apb_addr[7:2]] = bus.apb_wdata;
            bus.apb_rdata = $urandom;
          end else begin
            bus.apb_rdata = slv_mem[bus.apb_addr[7:2]];
          end
        end else begin
          bus.apb_ready = 1'b0;
          bus.apb_rdata = $urandom;
        end
        slv_cnt++;
      end else begin
        slv_cnt = 0;
        bus.apb_ready = 1'($urandom_range(0, 1));
        bus.apb_rdata = $urandom;
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_req_ready"}, bus.req_ready, 32'd1);
    check_val({tag, "_rsp_valid"}, bus.rsp_valid, 32'd0);
    check_val({tag, "_rsp_err"},   bus.rsp_err,   32'd0);
    check_val({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'd0);
    check_val({tag, "_apb_sel"},   bus.apb_sel,   32'd0);
    check_val({tag, "_apb_en"},    bus.apb_en,    32'd0);
    check_val({tag, "_apb_write"}, bus.apb_write, 32'd0);
    check_val({tag, "_apb_addr"},  bus.apb_addr,  32'd0);
    check_val({tag, "_apb_wdata"}, bus.apb_wdata, 32'd0);
  endtask

  // driver: one full command, phase-by-phase checks; returns the accept cycle
  task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int waits, input int rsp_hold, output int acc_cyc);
    logic [31:0] exp_rd;
    logic [31:0] want;
    int          exp_acc;
    int          acc;
    bit          timed_out;
    bit          done;
    timed_out = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
    timed_out = (waits >= TB_TIMEOUT);
`endif
    exp_acc = timed_out ? TB_TIMEOUT : waits + 1;
    if (timed_out) begin
      exp_rd = '0;
    end else if (wr) begin
      model_mem[addr[7:2]] = wdata;
      exp_rd = '0;
    end else begin
      exp_rd = model_mem[addr[7:2]];
    end
    exp_q.push_back(exp_rd);

    slv_waits     = waits;
    bus.rsp_ready = (rsp_hold == 0);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(negedge clk);
    check_val("idle_req_ready", bus.req_ready, 32'd1);
    check_val("idle_rsp_valid", bus.rsp_valid, 32'd0);
    @(posedge clk);
    acc_cyc = cyc;
    #1;
    bus.req_valid = 1'b0;
    bus.req_write = ~wr;
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;

    @(negedge clk);
    check_val("setup_sel_en",    {bus.apb_sel, bus.apb_en}, 32'd2);
    check_val("setup_addr",      bus.apb_addr, addr);
    check_val("setup_write",     bus.apb_write, wr);
    check_val("setup_wdata",     bus.apb_wdata, wdata);
    check_val("setup_req_ready", bus.req_ready, 32'd0);

    acc  = 0;
    done = 1'b0;
    while (!done && acc < 200) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        done = 1'b1;
      end else begin
        acc++;
        check_val("access_sel_en", {bus.apb_sel, bus.apb_en}, 32'd3);
        check_val("access_addr",   bus.apb_addr, addr);
        check_val("access_write",  bus.apb_write, wr);
        check_val("access_wdata",  bus.apb_wdata, wdata);
      end
    end
    check_val("resp_seen", done, 32'd1);
    check_val("access_cycles", acc, exp_acc);
    want = exp_q.pop_front();
    check_val("rsp_rdata",       bus.rsp_rdata, want);
    check_val("rsp_err",         bus.rsp_err, timed_out);
    check_val("resp_sel_en",     {bus.apb_sel, bus.apb_en}, 32'd0);
    check_val("resp_req_ready",  bus.req_ready, 32'd0);

    for (int i = 0; i < rsp_hold; i++) begin
      bus.req_valid = 1'b1;
      bus.req_write = nxt_wr;
      bus.req_addr  = nxt_addr;
      bus.req_wdata = nxt_wdata;
      @(posedge clk);
      @(negedge clk);
      check_val("hold_rsp_valid", bus.rsp_valid, 32'd1);
      check_val("hold_rsp_rdata", bus.rsp_rdata, want);
      check_val("hold_rsp_err",   bus.rsp_err, timed_out);
      check_val("hold_req_ready", bus.req_ready, 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          a0;
    int          a1;
    int          seen;
    int          waits;
    int          hold;
    int          prev_len;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] v;

    rstn          = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      v = $urandom;
      slv_mem[i]   = v;
      model_mem[i] = v;
    end

    #12;
    check_reset_outputs("rst");
    check_val("rst_state", dbg_state, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // write 0x100 <- 0x5A, zero wait states
    run_cmd(1'b1, 32'h100, 32'h5A, 0, 0, a0);

    // read 0x104 returning 0xC3 after 3 wait states
    slv_mem[1]   = 32'hC3;
    model_mem[1] = 32'hC3;
    run_cmd(1'b0, 32'h104, 32'h0, 3, 0, a0);

    // response held off 5 cycles while a second command waits
    nxt_wr    = 1'b1;
    nxt_addr  = 32'h108;
    nxt_wdata = 32'hDEAD_BEEF;
    run_cmd(1'b0, 32'h100, 32'h0, 0, 5, a0);
    run_cmd(nxt_wr, nxt_addr, nxt_wdata, 0, 0, a1);
    check_val("accept_after_hold", a1 - a0, 32'd9);
    run_cmd(1'b0, 32'h108, 32'h0, 1, 0, a0);

`ifdef APB_MASTER_TIMEOUT_EN
    run_cmd(1'b1, 32'h10C, 32'h1234, 1000, 0, a0);
    run_cmd(1'b0, 32'h10C, 32'h0, 1000, 0, a0);
    run_cmd(1'b0, 32'h104, 32'h0, TB_TIMEOUT - 1, 0, a0);
`endif

    // asynchronous reset in the middle of a read ACCESS
    slv_waits     = 8;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h104;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_val("pre_rst_access", {bus.apb_sel, bus.apb_en}, 32'd3);
    #2 rstn = 1'b0;
    #1 check_reset_outputs("arst");
    @(negedge clk);
    rstn = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    check_val("no_rsp_after_rst", seen, 32'd0);
    @(posedge clk);
    #1;
    run_cmd(1'b0, 32'h100, 32'h0, 2, 0, a0);

    // ten random back-to-back commands, zero wait states
    for (int k = 0; k < 10; k++) begin
      wr   = 1'($urandom_range(0, 1));
      addr = {24'h0, 2'b00, 4'($urandom_range(0, 15)), 2'b00};
      run_cmd(wr, addr, $urandom, 0, 0, a1);
      if (k > 0) check_val("b2b_period", a1 - a0, 32'd4);
      a0 = a1;
    end

    // random wait states and response back-pressure
    prev_len = 0;
    for (int k = 0; k < 10; k++) begin
      wr    = 1'($urandom_range(0, 1));
      addr  = {24'h0, 2'b00, 4'($urandom_range(0, 15)), 2'b00};
      waits = $urandom_range(0, 3);
      hold  = $urandom_range(0, 2);
      run_cmd(wr, addr, $urandom, waits, hold, a1);
      if (k > 0) check_val("rand_period", a1 - a0, prev_len);
      prev_len = 4 + waits + hold;
      a0 = a1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/i2c_apb_master.md
I2C_APB_MASTER -- requirements
Module: i2c_apb_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, is the number of ACCESS wait cycles (apb_ready low) before the transfer is aborted; legal range 1..65535.
REQ-002 clk  input  1  single clock; all logic on its rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  command request valid.
REQ-005 req_ready  output  1  command accepted when req_valid and req_ready are both high.
REQ-006 req_write  input  1  1 = APB write, 0 = APB read.
REQ-007 req_addr  input  32  APB byte address.
REQ-008 req_wdata  input  32  write data, ignored for reads.
REQ-009 rsp_valid  output  1  response valid.
REQ-010 rsp_ready  input  1  response consumed when rsp_valid and rsp_ready are both high.
REQ-011 rsp_rdata  output  32  read data; 0 for writes and for timed-out transfers.
REQ-012 rsp_err  output  1  1 = transfer timed out.
REQ-013 apb_sel, apb_en, apb_write  output  1 each  APB control.
REQ-014 apb_addr, apb_wdata  output  32 each  APB address and write data.
REQ-015 apb_ready  input  1  APB completion.
REQ-016 apb_rdata  input  32  APB read data.

Function
REQ-017 The FSM SHALL have 4 states: IDLE, SETUP, ACCESS and RESP.
REQ-018 IDLE: req_ready=1, all APB outputs 0; on req_valid, latch write/addr/wdata and go to SETUP.
REQ-019 SETUP (exactly 1 cycle): apb_sel=1, apb_en=0, and apb_addr, apb_write and apb_wdata driven from the latched values; go to ACCESS.
REQ-020 ACCESS: apb_sel=1, apb_en=1; the address, write and wdata outputs SHALL hold stable for the whole phase.
REQ-021 ACCESS with apb_ready=1: capture apb_rdata on that edge (reads only; writes capture 0), set rsp_err=0, go to RESP.
REQ-022 ACCESS with apb_ready=0: increment a 16-bit wait counter that is cleared on entry to SETUP.
REQ-023 In RESP, apb_sel=0 and apb_en=0, rsp_valid=1, and rsp_rdata/rsp_err SHALL hold until rsp_ready=1; then go to IDLE.
REQ-024 req_ready SHALL be 0 in SETUP, ACCESS and RESP; only one transfer is outstanding at a time.
REQ-025 Latency with zero wait states: accept at edge N, SETUP in cycle N+1, ACCESS in cycle N+2, rsp_valid in cycle N+3.
REQ-026 Back-to-back: the earliest next acceptance is the cycle after the RESP handshake, so 4 cycles per transfer minimum.
REQ-027 apb_ready SHALL be ignored outside ACCESS.
REQ-028 apb_rdata SHALL be ignored on writes and while apb_ready=0.
REQ-029 The wait counter SHALL saturate at 65535 and never wrap.

Reset
REQ-030 While rstn=0: state=IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, and apb_sel, apb_en, apb_write, apb_addr and apb_wdata all 0.
REQ-031 Reset asserted mid-transfer SHALL abort immediately and asynchronously; no response is produced for the aborted command.

Configuration
REQ-032 With macro APB_MASTER_TIMEOUT_EN defined: ACCESS with apb_ready=0 while the wait counter equals TIMEOUT_CYCLES-1 SHALL go to RESP with rsp_err=1 and rsp_rdata=0, deasserting apb_sel and apb_en.
REQ-033 Without APB_MASTER_TIMEOUT_EN: no timeout logic is built, ACCESS waits indefinitely, rsp_err is tied to 0, and the counter is still built for saturation checks only if the macro is defined.

Verification
REQ-034 Write addr 0x100, wdata 0x5A, apb_ready tied 1 -> SETUP with sel=1/en=0, ACCESS with sel=1/en=1, rsp_valid at N+3 with rsp_err=0 and rsp_rdata=0.
REQ-035 Read addr 0x104, slave returns 0x0000_00C3 after 3 wait cycles -> addr stable for 4 ACCESS cycles; rsp_rdata=0xC3, rsp_valid at N+6.
REQ-036 APB_MASTER_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, apb_ready held 0 -> 4 ACCESS cycles, then rsp_err=1, rsp_rdata=0, sel/en=0.
REQ-037 rsp_ready held 0 for 5 cycles, with req_valid high carrying a second command -> rsp_valid and rsp_rdata stable and req_ready=0 throughout; second command accepted the cycle after the handshake.
REQ-038 rstn pulsed low during ACCESS of a read -> outputs reach reset values asynchronously; no rsp_valid follows; the next command completes normally.
REQ-039 Ten random back-to-back commands against a register model, rsp_ready=1 -> every read matches the model and each transfer takes exactly 4 cycles.
